mat_operand_loader: RTL and testbench

- Upstream feeder for the 4x4-by-4x2 matrix multiplier.
- Accepts a stream of 4-bit elements over a valid/ready handshake and assembles one full operand frame:
  - 16 elements of A, row-major, A0..A15;
  - then 8 elements of B, row-major, B0..B7.
- Presents the frame as stable registered flat buses with a valid/ready handoff to the multiplier and its result-capture stage.
- Resynchronises on a start-of-frame marker.

---
 rtl/mat_operand_loader.sv | 109 ++++++++++
 tb/tb_mat_operand_loader.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_operand_loader.sv
// Operand frame assembler for the 4x4-by-4x2 matrix multiplier: collects NA elements of A
// then NB elements of B from a valid/ready stream and holds them on flat buses until consumed.
module mat_operand_loader #(
   parameter int unsigned DATA_W = 4,
   parameter int unsigned NA     = 16,
   parameter int unsigned NB     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATA_W-1:0]    in_data,
   input  logic                 in_sof,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [NA*DATA_W-1:0] a_flat,
   output logic [NB*DATA_W-1:0] b_flat,
   output logic                 frame_err,
   output logic [4:0]           elem_idx
);

   localparam int unsigned NElem   = NA + NB;
   localparam logic [4:0]  LastIdx = 5'(NElem - 1);

   typedef enum logic [0:0] {StLoad, StHold} state_e;

   state_e                state_q;
   logic [4:0]            idx_q;
   logic [NA*DATA_W-1:0]  a_q;
   logic [NB*DATA_W-1:0]  b_q;
   logic                  in_ready_q;
   logic                  out_valid_q;
   logic                  frame_err_q;
   logic                  accept;

   // in_ready_q is only set in StLoad, so an accept implies the load state.
   assign accept = in_valid && in_ready_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StLoad;
         idx_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         frame_err_q <= 1'b0;
         unique case (state_q)
            StLoad: begin
               if (accept) begin
                  if (in_sof) begin
                     // Resync: restart at A0; stale slots are overwritten as the frame refills.
                     a_q[DATA_W-1:0] <= in_data;
                     idx_q           <= 5'd1;
                     frame_err_q     <= (idx_q != 5'd0);
                  end else begin
                     for (int unsigned k = 0; k < NA; k++) begin
                        if (idx_q == 5'(k)) a_q[k*DATA_W +: DATA_W] <= in_data;
                     end
                     for (int unsigned k = 0; k < NB; k++) begin
                        if (idx_q == 5'(NA + k)) b_q[k*DATA_W +: DATA_W] <= in_data;
                     end
                     if (idx_q == LastIdx) begin
                        idx_q       <= '0;
                        state_q     <= StHold;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                     end else begin
                        idx_q <= idx_q + 5'd1;
                     end
                  end
               end
            end
            StHold: begin
               // Handoff cycle accepts nothing upstream: one bubble per frame.
               if (out_ready) begin
                  state_q     <= StLoad;
                  in_ready_q  <= 1'b1;
                  out_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= StLoad;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign a_flat    = a_q;
   assign b_flat    = b_q;
   assign frame_err = frame_err_q;
   assign elem_idx  = idx_q;

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (idx_q <= LastIdx) else $error("elem_idx out of range: %0d", idx_q);
         assert (in_ready_q ^ out_valid_q) else $error("in_ready/out_valid not exclusive");
      end
   end
`endif

endmodule

// File: tb/tb_mat_operand_loader.sv
// Directed self-checking bench for mat_operand_loader: frame fill, hold, back-to-back,
// resync, resets and gapped input.
module tb_mat_operand_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_data;
   logic        in_sof;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] a_flat;
   logic [31:0] b_flat;
   logic        frame_err;
   logic [4:0]  elem_idx;

   int checks = 0;
   int errors = 0;

   localparam logic [63:0] BasicA = 64'h0FED_CBA9_8765_4321;
   localparam logic [31:0] BasicB = 32'h2222_2222;

   mat_operand_loader #(
      .DATA_W (4),
      .NA     (16),
      .NB     (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sof    (in_sof),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .a_flat    (a_flat),
      .b_flat    (b_flat),
      .frame_err (frame_err),
      .elem_idx  (elem_idx)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [3:0] d, input logic sof);
      in_valid = 1'b1;
      in_data  = d;
      in_sof   = sof;
      cycle();
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_data  = 4'h0;
   endtask

   function automatic logic [3:0] basic_elem(input int b);
      if (b < 15) return 4'(b + 1);
      if (b == 15) return 4'h0;
      return 4'h2;
   endfunction

   task automatic check_idle_reset(input string tag);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || elem_idx !== 5'd0 || a_flat !== 64'h0 ||
          b_flat !== 32'h0 || frame_err !== 1'b0) begin
         errors++;
         $display("FAIL %s: got ov=%b ir=%b idx=%0d a=%h b=%h fe=%b, expected ov=0 ir=1 idx=0 a=0 b=0 fe=0",
                  tag, out_valid, in_ready, elem_idx, a_flat, b_flat, frame_err);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_data = 4'h0; in_sof = 1'b0; out_ready = 1'b0;
      cycle();
      cycle();
      rst = 1'b0;
      check_idle_reset("reset_state");
   endtask

   task automatic test_basic_frame();
      for (int b = 0; b < 24; b++) begin
         send_beat(basic_elem(b), b == 0);
         if (b == 11) begin
            checks++;
            if (elem_idx !== 5'd12) begin
               errors++;
               $display("FAIL basic_idx12: got %0d, expected 12", elem_idx);
            end
         end
         if (b == 22) begin
            checks++;
            if (out_valid !== 1'b0) begin
               errors++;
               $display("FAIL basic_early_valid: got %b, expected 0", out_valid);
            end
         end
      end
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || elem_idx !== 5'd0) begin
         errors++;
         $display("FAIL basic_hold: got ov=%b ir=%b idx=%0d, expected ov=1 ir=0 idx=0",
                  out_valid, in_ready, elem_idx);
      end
      checks++;
      if (a_flat !== BasicA || b_flat !== BasicB) begin
         errors++;
         $display("FAIL basic_data: got a=%h b=%h, expected a=%h b=%h", a_flat, b_flat, BasicA, BasicB);
      end
   endtask

   task automatic test_backpressure();
      int bad = 0;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 4'hF;
      for (int c = 0; c < 10; c++) begin
         cycle();
         if (a_flat !== BasicA || b_flat !== BasicB || elem_idx !== 5'd0 || out_valid !== 1'b1 ||
             in_ready !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL bp_hold: got %0d disturbed cycles (a=%h b=%h idx=%0d), expected 0",
                  bad, a_flat, b_flat, elem_idx);
      end
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || a_flat !== BasicA || elem_idx !== 5'd0) begin
         errors++;
         $display("FAIL bp_handoff: got ov=%b ir=%b a=%h idx=%0d, expected ov=0 ir=1 a=%h idx=0",
                  out_valid, in_ready, a_flat, elem_idx, BasicA);
      end
      in_valid = 1'b0;
      in_data  = 4'h0;
   endtask

   task automatic test_back_to_back();
      int b = 0;
      int hi[$];
      logic acc;
      out_ready = 1'b1;
      for (int c = 0; c < 50; c++) begin
         if (b < 48) begin
            in_valid = 1'b1;
            in_data  = (b < 24) ? 4'h3 : 4'hC;
            in_sof   = (b % 24 == 0);
         end else begin
            in_valid = 1'b0;
            in_sof   = 1'b0;
         end
         acc = in_valid && in_ready;
         cycle();
         if (acc) b++;
         if (out_valid === 1'b1) begin
            hi.push_back(c);
            checks++;
            if (hi.size() == 1 && (a_flat !== {16{4'h3}} || b_flat !== {8{4'h3}})) begin
               errors++;
               $display("FAIL b2b_frame1: got a=%h b=%h, expected all 3", a_flat, b_flat);
            end else if (hi.size() == 2 && (a_flat !== {16{4'hC}} || b_flat !== {8{4'hC}})) begin
               errors++;
               $display("FAIL b2b_frame2: got a=%h b=%h, expected all C", a_flat, b_flat);
            end
         end
      end
      in_valid = 1'b0; in_sof = 1'b0; in_data = 4'h0; out_ready = 1'b0;
      checks++;
      if (hi.size() != 2) begin
         errors++;
         $display("FAIL b2b_pulses: got %0d valid cycles, expected 2", hi.size());
      end else if (hi[0] != 23 || hi[1] - hi[0] != 25) begin
         errors++;
         $display("FAIL b2b_period: got first=%0d period=%0d, expected first=23 period=25",
                  hi[0], hi[1] - hi[0]);
      end
      checks++;
      if (b != 48 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_beats: got beats=%0d ir=%b, expected beats=48 ir=1", b, in_ready);
      end
   endtask

   task automatic test_resync();
      send_beat(4'h5, 1'b1);
      checks++;
      if (frame_err !== 1'b0) begin
         errors++;
         $display("FAIL resync_clean_sof: got frame_err=%b, expected 0", frame_err);
      end
      for (int i = 0; i < 6; i++) send_beat(4'h5, 1'b0);
      send_beat(4'h9, 1'b1);
      checks++;
      if (frame_err !== 1'b1 || elem_idx !== 5'd1 || a_flat[3:0] !== 4'h9) begin
         errors++;
         $display("FAIL resync_sof: got fe=%b idx=%0d a0=%h, expected fe=1 idx=1 a0=9",
                  frame_err, elem_idx, a_flat[3:0]);
      end
      cycle();
      checks++;
      if (frame_err !== 1'b0 || elem_idx !== 5'd1) begin
         errors++;
         $display("FAIL resync_pulse_len: got fe=%b idx=%0d, expected fe=0 idx=1", frame_err, elem_idx);
      end
      for (int i = 0; i < 23; i++) begin
         send_beat(4'h1, 1'b0);
         if (i == 21) begin
            checks++;
            if (out_valid !== 1'b0) begin
               errors++;
               $display("FAIL resync_early: got ov=%b, expected 0", out_valid);
            end
         end
      end
      checks++;
      if (out_valid !== 1'b1 || a_flat !== 64'h1111_1111_1111_1119 || b_flat !== 32'h1111_1111) begin
         errors++;
         $display("FAIL resync_frame: got ov=%b a=%h b=%h, expected ov=1 a=1111111111111119 b=11111111",
                  out_valid, a_flat, b_flat);
      end
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
   endtask

   task automatic test_gapped();
      int bad = 0;
      for (int b = 0; b < 24; b++) begin
         send_beat(basic_elem(b), b == 0);
         // Idle cycle with a stray sof and data but no valid.
         in_sof  = 1'b1;
         in_data = 4'hF;
         cycle();
         in_sof  = 1'b0;
         in_data = 4'h0;
         if (elem_idx !== 5'((b + 1) % 24) || frame_err !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL gapped_idx: got %0d bad gap cycles, expected 0", bad);
      end
      checks++;
      if (out_valid !== 1'b1 || a_flat !== BasicA || b_flat !== BasicB) begin
         errors++;
         $display("FAIL gapped_frame: got ov=%b a=%h b=%h, expected ov=1 a=%h b=%h",
                  out_valid, a_flat, b_flat, BasicA, BasicB);
      end
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      for (int b = 0; b < 12; b++) send_beat(4'h7, b == 0);
      in_valid = 1'b1;
      in_data  = 4'h7;
      rst      = 1'b1;
      cycle();
      rst      = 1'b0;
      in_valid = 1'b0;
      in_data  = 4'h0;
      check_idle_reset("reset_mid_load");
      for (int b = 0; b < 24; b++) send_beat(4'hA, b == 0);
      checks++;
      if (out_valid !== 1'b1 || a_flat !== {16{4'hA}}) begin
         errors++;
         $display("FAIL reset_refill: got ov=%b a=%h, expected ov=1 a=all A", out_valid, a_flat);
      end
      rst       = 1'b1;
      out_ready = 1'b1;
      cycle();
      rst       = 1'b0;
      out_ready = 1'b0;
      check_idle_reset("reset_mid_hold");
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_backpressure();
      test_back_to_back();
      test_resync();
      test_gapped();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
